pclk_seq: RTL and testbench

PCLK_SEQ -- requirements
Module: pclk_seq

---
 rtl/pclk_seq.sv | 73 +++++++
 tb/tb_pclk_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pclk_seq.sv
// rtl/pclk_seq.sv - four-phase power-clock sequencer with quarter counter and clean drain
// Phase k runs UP/HOLD/DN/WAIT offset by k quarters; each phase re-arms only at its own UP boundary.
module pclk_seq #(
   parameter int              CNT_W    = 4,
   parameter logic [CNT_W-1:0] QLEN_RST = 4'd3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_req,
   input  logic [CNT_W-1:0] qlen_in,
   output logic [7:0]       ph_st,
   output logic [CNT_W-1:0] ramp_step,
   output logic [1:0]       quarter,
   output logic             tick,
   output logic             busy,
   output logic             run_ack
);

   localparam logic [1:0] ST_WAIT = 2'b11;

   logic [CNT_W-1:0] qlen_r;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       q;
   logic [3:0]       act;
   logic             idle;
   logic             boundary;
   logic [1:0]       q_nxt;
   logic [3:0]       act_bnd;

   assign idle     = (act == 4'b0000);
   assign boundary = !idle && (cnt == qlen_r);
   assign q_nxt    = q + 2'd1;

   // At a boundary only the phase about to enter UP samples run_req.
   always_comb begin
      act_bnd        = act;
      act_bnd[q_nxt] = run_req;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act    <= 4'b0000;
         cnt    <= '0;
         q      <= 2'd0;
         qlen_r <= QLEN_RST;
      end else if (idle) begin
         qlen_r <= qlen_in;
         cnt    <= '0;
         q      <= 2'd0;
         act    <= {3'b000, run_req};
      end else if (boundary) begin
         cnt <= '0;
         q   <= (act_bnd == 4'b0000) ? 2'd0 : q_nxt;
         act <= act_bnd;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      ph_st = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         ph_st[2*k +: 2] = act[k] ? (q - 2'(k)) : ST_WAIT;
      end
   end

   assign ramp_step = cnt;
   assign quarter   = q;
   assign tick      = boundary;
   assign busy      = !idle;
   assign run_ack   = &act;

endmodule

// File: tb/tb_pclk_seq.sv
// tb/tb_pclk_seq.sv - directed and random checks of pclk_seq against a cycle-count reference model
module tb_pclk_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       run_req;
   logic [3:0] qlen_in;
   logic [7:0] ph_st;
   logic [3:0] ramp_step;
   logic [1:0] quarter;
   logic       tick;
   logic       busy;
   logic       run_ack;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   pclk_seq dut (
      .clk      (clk),
      .rst      (rst),
      .run_req  (run_req),
      .qlen_in  (qlen_in),
      .ph_st    (ph_st),
      .ramp_step(ramp_step),
      .quarter  (quarter),
      .tick     (tick),
      .busy     (busy),
      .run_ack  (run_ack)
   );

   // Model: per-phase enable flags plus cycles elapsed since the run started.
   bit m_act [4];
   int m_n;
   int m_len;

   function automatic bit m_busy();
      return m_act[0] | m_act[1] | m_act[2] | m_act[3];
   endfunction

   function automatic bit m_all();
      return m_act[0] & m_act[1] & m_act[2] & m_act[3];
   endfunction

   function automatic int m_quarter();
      return m_busy() ? (m_n / m_len) % 4 : 0;
   endfunction

   function automatic int m_step();
      return m_busy() ? m_n % m_len : 0;
   endfunction

   function automatic bit m_tick();
      return m_busy() && (m_step() == m_len - 1);
   endfunction

   function automatic logic [7:0] m_ph();
      logic [7:0] r;
      int code;
      r = 8'h00;
      for (int k = 0; k < 4; k++) begin
         code = m_act[k] ? (m_quarter() - k + 4) % 4 : 3;
         r[2*k +: 2] = 2'(code);
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_act[k] = 1'b0;
      m_n   = 0;
      m_len = 4;
   endtask

   task automatic model_edge(input bit rr, input int ql);
      bit t;
      int nq;
      if (!m_busy()) begin
         m_len    = ql + 1;
         m_n      = 0;
         m_act[0] = rr;
      end else begin
         t  = m_tick();
         nq = (m_quarter() + 1) % 4;
         if (t) m_act[nq] = rr;
         if (!m_busy()) m_n = 0;
         else           m_n = m_n + 1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("ph_st",     ph_st,             m_ph());
      chk("ramp_step", 8'(ramp_step),     8'(m_step()));
      chk("quarter",   8'(quarter),       8'(m_quarter()));
      chk("tick",      8'(tick),          8'(m_tick()));
      chk("busy",      8'(busy),          8'(m_busy()));
      chk("run_ack",   8'(run_ack),       8'(m_all()));
   endtask

   task automatic cyc(input bit rr, input int ql);
      run_req = rr;
      qlen_in = 4'(ql);
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge(rr, ql);
      @(negedge clk);
      check_all();
   endtask

   task automatic drain(input int ql);
      for (int i = 0; i < 80; i++) begin
         if (!m_busy()) break;
         cyc(1'b0, ql);
      end
      chk("drain_busy", 8'(busy), 8'h00);
      chk("drain_ph",   ph_st,    8'hFF);
   endtask

   logic [7:0] exp_start [10];
   bit         rr_r;

   initial begin
      exp_start = '{8'hFC, 8'hFC, 8'hF1, 8'hF1, 8'hC6, 8'hC6, 8'h1B, 8'h1B, 8'h6C, 8'h6C};
      rst     = 1'b1;
      run_req = 1'b0;
      qlen_in = 4'd1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      chk("rst_ph", ph_st, 8'hFF);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) cyc(1'b0, 1);

      // Start-up with two-cycle quarters
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1);
         chk("start_ph",   ph_st,       exp_start[i]);
         chk("start_tick", 8'(tick),    8'(i % 2));
         if (i == 5) chk("start_ack_lo", 8'(run_ack), 8'h00);
         if (i == 6) chk("start_ack_hi", 8'(run_ack), 8'h01);
      end

      // qlen_in change while busy must not alter the quarter length
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 5);
         chk("lock_step", 8'(ramp_step <= 4'd1), 8'h01);
      end
      drain(5);

      // Next run picks up six-cycle quarters latched while idle
      cyc(1'b1, 5);
      for (int i = 1; i < 13; i++) begin
         cyc(1'b1, 1);
         if (i == 5) chk("len6_step", 8'(ramp_step), 8'h05);
         if (i == 6) chk("len6_q",    8'(quarter),   8'h01);
      end
      drain(1);

      // Re-request mid-drain: skip exactly one boundary
      for (int i = 0; i < 12; i++) cyc(1'b1, 1);
      for (int i = 0; i < 4 && !m_tick(); i++) cyc(1'b1, 1);
      chk("skip_tick", 8'(tick), 8'h01);
      cyc(1'b0, 1);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1);
         chk("skip_busy", 8'(busy), 8'h01);
      end
      chk("skip_ack", 8'(run_ack), 8'h01);
      drain(1);

      // One-cycle quarters
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 0);
         chk("q0_tick", 8'(tick), 8'h01);
      end
      drain(0);

      // Random run_req/qlen_in sequences
      rr_r = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) rr_r = ~rr_r;
         cyc(rr_r, int'($urandom_range(0, 3)));
      end
      drain(2);

      // Asynchronous reset in the middle of phase 0 HOLD
      cyc(1'b1, 2);
      for (int i = 0; i < 20 && !(m_quarter() == 1 && m_step() == 1); i++) cyc(1'b1, 2);
      chk("hold_q", 8'(quarter), 8'h01);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst_ph",   ph_st,          8'hFF);
      chk("arst_step", 8'(ramp_step),  8'h00);
      chk("arst_q",    8'(quarter),    8'h00);
      chk("arst_tick", 8'(tick),       8'h00);
      chk("arst_busy", 8'(busy),       8'h00);
      chk("arst_ack",  8'(run_ack),    8'h00);
      cyc(1'b1, 2);
      cyc(1'b1, 2);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b0, 2);
      chk("post_rst_idle", 8'(busy), 8'h00);
      for (int i = 0; i < 10; i++) cyc(1'b1, 2);
      drain(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
